// File: rtl/rdc_clk_dis_seq.sv
// Reset-domain-crossing sequencer: quiesce bus, gate clocks, pulse core warm reset, ungate, release.
// Optional macro RDC_SEQ_QUIESCE_TIMEOUT_EN bounds the quiesce wait to QUIESCE_MAX cycles.
module rdc_clk_dis_seq #(
    parameter int unsigned DIS_CYCLES  = 4,
    parameter int unsigned RST_CYCLES  = 8,
    parameter int unsigned REL_CYCLES  = 2,
    parameter int unsigned QUIESCE_MAX = 256,
    parameter int unsigned CNT_W       = 9
) (
    input  logic clk,
    input  logic cptra_rst_b,
    input  logic rst_req,
    input  logic bus_idle,
    output logic rdc_clk_dis,
    output logic core_rst_b,
    output logic seq_busy,
    output logic seq_done,
    output logic quiesce_timeout
);

    typedef enum logic [2:0] {
        IDLE, QUIESCE, CLK_DIS, RST_ASSERT, CLK_EN, DONE
    } state_e;

    localparam logic [CNT_W-1:0] DIS_LD = CNT_W'(DIS_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LD = CNT_W'(REL_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             rdc_q, rdc_d;
    logic             core_q, core_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmo_hit;

`ifdef RDC_SEQ_QUIESCE_TIMEOUT_EN
    localparam logic [CNT_W-1:0] QMAX_LD = CNT_W'(QUIESCE_MAX - 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             tmo_flag_q, tmo_flag_d;

    // Counter sits at zero outside QUIESCE, so every entry starts a fresh window.
    assign tmo_hit    = (state_q == QUIESCE) && !bus_idle && (tmo_cnt_q == QMAX_LD);
    assign tmo_cnt_d  = (state_q == QUIESCE) ? tmo_cnt_q + 1'b1 : '0;
    assign tmo_flag_d = tmo_flag_q | tmo_hit;

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign quiesce_timeout = tmo_flag_q;
`else
    assign tmo_hit         = 1'b0;
    assign quiesce_timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        pend_d  = pend_q | (rst_req && (state_q != IDLE));
        rdc_d   = rdc_q;
        core_d  = core_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                core_d = 1'b1;
                if (rst_req || pend_q) begin
                    state_d = QUIESCE;
                    pend_d  = 1'b0;
                end
            end
            QUIESCE: begin
                if (bus_idle || tmo_hit) begin
                    state_d = CLK_DIS;
                    rdc_d   = 1'b1;
                    cnt_d   = DIS_LD;
                end
            end
            CLK_DIS: begin
                if (cnt_q == '0) begin
                    state_d = RST_ASSERT;
                    core_d  = 1'b0;
                    cnt_d   = RST_LD;
                end
            end
            RST_ASSERT: begin
                if (cnt_q == '0) begin
                    state_d = CLK_EN;
                    rdc_d   = 1'b0;
                    cnt_d   = REL_LD;
                end
            end
            CLK_EN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    core_d  = 1'b1;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge cptra_rst_b) begin
        if (!cptra_rst_b) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            rdc_q   <= 1'b0;
            core_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            rdc_q   <= rdc_d;
            core_q  <= core_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rdc_clk_dis = rdc_q;
    assign core_rst_b  = core_q;
    assign seq_busy    = busy_q;
    assign seq_done    = done_q;

endmodule

// File: tb/tb_rdc_clk_dis_seq.sv
// Bench for rdc_clk_dis_seq: directed + random steps against a timeline model of the reset sequence.
module tb_rdc_clk_dis_seq;

    localparam int DIS  = 4;
    localparam int RST  = 8;
    localparam int REL  = 2;
    localparam int QMAX = 256;
    localparam int TOT  = DIS + RST + REL;

    logic clk = 1'b0;
    logic cptra_rst_b = 1'b0;
    logic rst_req = 1'b0;
    logic bus_idle = 1'b0;
    logic rdc_clk_dis, core_rst_b, seq_busy, seq_done, quiesce_timeout;

    rdc_clk_dis_seq dut (
        .clk             (clk),
        .cptra_rst_b     (cptra_rst_b),
        .rst_req         (rst_req),
        .bus_idle        (bus_idle),
        .rdc_clk_dis     (rdc_clk_dis),
        .core_rst_b      (core_rst_b),
        .seq_busy        (seq_busy),
        .seq_done        (seq_done),
        .quiesce_timeout (quiesce_timeout)
    );

    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;
    int n = 0;
    int done_cnt = 0;
    int d0 = 0;
    // Model: a sequence is described by the edge it entered QUIESCE and the edge clocks were disabled.
    int q_edge = -1;
    int b_edge = -1;
    bit pend = 1'b0;
    bit tmo = 1'b0;
    bit rst_seen = 1'b0;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %b expected %b at edge %0d", tag, obs, exp, n);
    endtask

    task automatic check_outs();
        logic e_rdc, e_core, e_busy, e_done;
        int   t;
        e_rdc  = 1'b0;
        e_core = rst_seen;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (q_edge >= 0) begin
            e_busy = 1'b1;
            if (b_edge >= 0) begin
                t      = n - b_edge;
                e_rdc  = (t < DIS + RST);
                e_core = !(t >= DIS && t < TOT);
                e_done = (t == TOT);
            end
        end
        chk("rdc_clk_dis", rdc_clk_dis, e_rdc);
        chk("core_rst_b", core_rst_b, e_core);
        chk("seq_busy", seq_busy, e_busy);
        chk("seq_done", seq_done, e_done);
        chk("quiesce_timeout", quiesce_timeout, tmo);
    endtask

    task automatic model_reset();
        q_edge   = -1;
        b_edge   = -1;
        pend     = 1'b0;
        tmo      = 1'b0;
        rst_seen = 1'b0;
    endtask

    task automatic step(input bit req, input bit idle);
        rst_req  = req;
        bus_idle = idle;
        @(posedge clk);
        n++;
        if (q_edge < 0) begin
            if (req || pend) begin
                q_edge = n;
                pend   = 1'b0;
            end
        end else begin
            if (req) pend = 1'b1;
            if (b_edge < 0) begin
                if (idle) b_edge = n;
`ifdef RDC_SEQ_QUIESCE_TIMEOUT_EN
                else if (n - q_edge == QMAX) begin
                    b_edge = n;
                    tmo    = 1'b1;
                end
`endif
            end else if (n - b_edge == TOT + 1) begin
                q_edge = -1;
                b_edge = -1;
            end
        end
        rst_seen = 1'b1;
        #1;
        if (seq_done === 1'b1) done_cnt++;
        check_outs();
    endtask

    initial begin
        // reset values
        bus_idle = 1'b1;
        model_reset();
        #1 check_outs();
        @(posedge clk); #1 check_outs();
        cptra_rst_b = 1'b1;

        // basic sequence
        step(1'b1, 1'b1);
        repeat (20) step(1'b0, 1'b1);
        chk("one_done", logic'(done_cnt == 1), 1'b1);

        // quiesce stall
        step(1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);

        // second request while in RST_ASSERT
        d0 = done_cnt;
        step(1'b1, 1'b1);
        repeat (8) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        repeat (40) step(1'b0, 1'b1);
        chk("two_done", logic'(done_cnt - d0 == 2), 1'b1);

        // async reset during CLK_DIS
        d0 = done_cnt;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #2 cptra_rst_b = 1'b0;
        model_reset();
        #1 check_outs();
        @(posedge clk); #1 check_outs();
        cptra_rst_b = 1'b1;
        repeat (6) step(1'b0, 1'b1);
        chk("no_done_after_rst", logic'(done_cnt == d0), 1'b1);

        // randomized traffic
        repeat (300) step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        repeat (30) step(1'b0, 1'b1);

`ifdef RDC_SEQ_QUIESCE_TIMEOUT_EN
        // quiesce timeout
        step(1'b1, 1'b0);
        repeat (300) step(1'b0, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        chk("timeout_sticky", quiesce_timeout, 1'b1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
